// File: rtl/fixed_point_pkg.sv
// Shared fixed-point constants and control-state encoding for the
// sign-magnitude multiply/add pipeline stages.
package fixed_point_pkg;

    localparam int DEFAULT_NUMBER_OF_BITS      = 16;
    localparam int DEFAULT_NUMBER_OF_FRAC_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add sign-magnitude fixed-point multiplier with saturation
// and a valid/ready handshake on both sides.
module seq_multiplier
    import fixed_point_pkg::*;
#(
    parameter int Number_of_bits      = DEFAULT_NUMBER_OF_BITS,
    parameter int Number_of_frac_bits = DEFAULT_NUMBER_OF_FRAC_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [Number_of_bits-1:0] op1,
    input  logic [Number_of_bits-1:0] op2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Number_of_bits-1:0] result,
    output logic                      overflow
);

    localparam int MAG_W = Number_of_bits - 1;
    localparam int PP_W  = 2 * MAG_W;
    localparam int CNT_W = $clog2(MAG_W + 1);

    fsm_state_t                state_r, state_s;
    logic [PP_W-1:0]           mcand_r, mcand_s;
    logic [MAG_W-1:0]          mplier_r, mplier_s;
    logic [PP_W-1:0]           partial_r, partial_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s;
    logic                      sign_r, sign_s;
    logic [Number_of_bits-1:0] result_r, result_s;
    logic                      overflow_r, overflow_s;
    logic                      out_valid_r, out_valid_s;
    logic                      in_ready_r, in_ready_s;
    logic [PP_W-1:0]           shifted_s;
    logic                      sat_s;
    logic [MAG_W-1:0]          mag_s;

    // State and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            mcand_r     <= {PP_W{1'b0}};
            mplier_r    <= {MAG_W{1'b0}};
            partial_r   <= {PP_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sign_r      <= 1'b0;
            result_r    <= {Number_of_bits{1'b0}};
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            mcand_r     <= mcand_s;
            mplier_r    <= mplier_s;
            partial_r   <= partial_s;
            cnt_r       <= cnt_s;
            sign_r      <= sign_s;
            result_r    <= result_s;
            overflow_r  <= overflow_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
        end
    end

    // Next-state, shift-add iteration and saturating result formation
    always_comb begin
        state_s     = state_r;
        mcand_s     = mcand_r;
        mplier_s    = mplier_r;
        partial_s   = partial_r;
        cnt_s       = cnt_r;
        sign_s      = sign_r;
        result_s    = result_r;
        overflow_s  = overflow_r;
        out_valid_s = out_valid_r;
        in_ready_s  = in_ready_r;

        // Truncating shift drops fraction bits; anything above MAG_W saturates
        shifted_s = partial_r >> Number_of_frac_bits;
        sat_s     = |shifted_s[PP_W-1:MAG_W];
        if (sat_s) begin
            mag_s = {MAG_W{1'b1}};
        end else begin
            mag_s = shifted_s[MAG_W-1:0];
        end

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s    = BUSY;
                    mcand_s    = {{MAG_W{1'b0}}, op1[MAG_W-1:0]};
                    mplier_s   = op2[MAG_W-1:0];
                    partial_s  = {PP_W{1'b0}};
                    cnt_s      = CNT_W'(MAG_W);
                    sign_s     = op1[MAG_W] ^ op2[MAG_W];
                    in_ready_s = 1'b0;
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    if (mplier_r[0]) begin
                        partial_s = partial_r + mcand_r;
                    end else begin
                        partial_s = partial_r;
                    end
                    mcand_s  = mcand_r << 1;
                    mplier_s = mplier_r >> 1;
                    cnt_s    = cnt_r - CNT_W'(1);
                end else begin
                    // Zero magnitude never carries a sign
                    result_s    = {sign_r & (mag_s != {MAG_W{1'b0}}), mag_s};
                    overflow_s  = sat_s;
                    out_valid_s = 1'b1;
                    state_s     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
            end
        endcase
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;

endmodule
